// File: rtl/rvsteel_mtimer_scheduler_pkg.sv
// Shared constants for the machine-timer deadline scheduler: timer register map,
// control-register enable bit and FSM state encoding.
package rvsteel_mtimer_scheduler_pkg;

  localparam logic [4:0] TMR_ADDR_CR    = 5'h00;
  localparam logic [4:0] TMR_ADDR_CMPL  = 5'h0C;
  localparam logic [4:0] TMR_ADDR_CMPH  = 5'h10;

  localparam int unsigned CR_EN_BIT = 0;

  typedef enum logic [2:0] {
    ST_INIT_CR,
    ST_IDLE,
    ST_SCAN,
    ST_PROG_H1,
    ST_PROG_L,
    ST_PROG_H2,
    ST_SETTLE,
    ST_FIRE
  } state_e;

  // Control-register word that turns the timer on.
  function automatic logic [31:0] cr_enable_word();
    return 32'(1) << CR_EN_BIT;
  endfunction

endpackage

// File: rtl/rvsteel_mtimer_scheduler_bus.sv
// Single-outstanding write master towards the timer IO port: one-cycle request
// pulse on start, then hold busy until the timer responds.
module rvsteel_mtimer_scheduler_bus (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic        tmr_write_response_i,
  output logic [4:0]  tmr_rw_address_o,
  output logic [31:0] tmr_write_data_o,
  output logic        tmr_write_request_o,
  output logic        busy_o,
  output logic        done_c_o
);

  logic        req_q;
  logic        busy_q;
  logic [4:0]  addr_q;
  logic [31:0] data_q;

  // A new start may coincide with the completing response of the previous write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q  <= 1'b0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (start_i) begin
      req_q  <= 1'b1;
      busy_q <= 1'b1;
      addr_q <= addr_i;
      data_q <= data_i;
    end else begin
      req_q <= 1'b0;
      if (busy_q && tmr_write_response_i) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign tmr_rw_address_o    = addr_q;
  assign tmr_write_data_o    = data_q;
  assign tmr_write_request_o = req_q;
  assign busy_o              = busy_q;
  assign done_c_o            = busy_q & tmr_write_response_i;

endmodule

// File: rtl/rvsteel_mtimer_scheduler.sv
// Multiplexes NUM_CHANNELS 64-bit deadlines onto the single mtimecmp of the
// machine timer and turns the timer interrupt into per-channel pending flags.
module rvsteel_mtimer_scheduler
  import rvsteel_mtimer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CH_WIDTH     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    arm_valid,
  output logic                    arm_ready,
  input  logic [CH_WIDTH-1:0]     arm_channel,
  input  logic                    arm_enable,
  input  logic [63:0]             arm_deadline,
  output logic [NUM_CHANNELS-1:0] pending,
  input  logic [NUM_CHANNELS-1:0] pending_clear,
  output logic                    irq,
  output logic [4:0]              tmr_rw_address,
  output logic [31:0]             tmr_write_data,
  output logic [3:0]              tmr_write_strobe,
  output logic                    tmr_write_request,
  input  logic                    tmr_write_response,
  input  logic                    tmr_irq
);

  localparam logic [CH_WIDTH-1:0] LAST_IDX  = CH_WIDTH'(NUM_CHANNELS - 1);
  localparam logic [CH_WIDTH:0]   NUM_CH_L  = (CH_WIDTH + 1)'(NUM_CHANNELS);

  state_e                  state_q, state_d;
  logic                    dirty_q, dirty_d;
  logic [NUM_CHANNELS-1:0] armed_q, armed_d;
  logic [63:0]             deadline_q [NUM_CHANNELS];
  logic [63:0]             target_q, target_d;
  logic [CH_WIDTH-1:0]     scan_idx_q, scan_idx_d;
  logic                    min_valid_q, min_valid_d;
  logic [63:0]             min_val_q, min_val_d;
  logic                    settle_q, settle_d;
  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic                    irq_q;
  logic                    arm_ready_q;

  logic                    arm_we_c;
  logic [NUM_CHANNELS-1:0] fire_set_c;
  logic                    bus_start_c;
  logic [4:0]              bus_addr_c;
  logic [31:0]             bus_data_c;
  logic                    bus_busy;
  logic                    bus_done_c;

  // Out-of-range channels complete the handshake but change nothing.
  assign arm_we_c = arm_valid && arm_ready_q &&
                    ((CH_WIDTH + 1)'(arm_channel) < NUM_CH_L);

  rvsteel_mtimer_scheduler_bus u_bus (
    .clock                (clock),
    .reset_n              (reset_n),
    .start_i              (bus_start_c),
    .addr_i               (bus_addr_c),
    .data_i               (bus_data_c),
    .tmr_write_response_i (tmr_write_response),
    .tmr_rw_address_o     (tmr_rw_address),
    .tmr_write_data_o     (tmr_write_data),
    .tmr_write_request_o  (tmr_write_request),
    .busy_o               (bus_busy),
    .done_c_o             (bus_done_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT_CR;
      dirty_q     <= 1'b0;
      armed_q     <= '0;
      target_q    <= '1;
      scan_idx_q  <= '0;
      min_valid_q <= 1'b0;
      min_val_q   <= '1;
      settle_q    <= 1'b0;
      pending_q   <= '0;
      irq_q       <= 1'b0;
      arm_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dirty_q     <= dirty_d;
      armed_q     <= armed_d;
      target_q    <= target_d;
      scan_idx_q  <= scan_idx_d;
      min_valid_q <= min_valid_d;
      min_val_q   <= min_val_d;
      settle_q    <= settle_d;
      pending_q   <= pending_d;
      irq_q       <= |pending_q;
      arm_ready_q <= (state_d == ST_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        deadline_q[i] <= '0;
      end
    end else if (arm_we_c) begin
      deadline_q[arm_channel] <= arm_deadline;
    end
  end

  always_comb begin
    state_d     = state_q;
    dirty_d     = dirty_q;
    armed_d     = armed_q;
    target_d    = target_q;
    scan_idx_d  = scan_idx_q;
    min_valid_d = min_valid_q;
    min_val_d   = min_val_q;
    settle_d    = settle_q;
    fire_set_c  = '0;
    bus_start_c = 1'b0;
    bus_addr_c  = '0;
    bus_data_c  = '0;

    if (arm_we_c) begin
      armed_d[arm_channel] = arm_enable;
      dirty_d              = 1'b1;
    end

    case (state_q)
      ST_INIT_CR: begin
        if (!bus_busy) begin
          bus_start_c = 1'b1;
          bus_addr_c  = TMR_ADDR_CR;
          bus_data_c  = cr_enable_word();
        end
        if (bus_done_c) begin
          state_d = ST_IDLE;
        end
      end
      // An arm in the same cycle is still covered: the scan reads the updated registers.
      ST_IDLE: begin
        if (dirty_q) begin
          state_d     = ST_SCAN;
          dirty_d     = 1'b0;
          scan_idx_d  = '0;
          min_valid_d = 1'b0;
          min_val_d   = '1;
        end else if (tmr_irq && (|armed_q)) begin
          state_d = ST_FIRE;
        end
      end
      ST_SCAN: begin
        if (armed_q[scan_idx_q] &&
            (!min_valid_q || (deadline_q[scan_idx_q] < min_val_q))) begin
          min_valid_d = 1'b1;
          min_val_d   = deadline_q[scan_idx_q];
        end
        if (scan_idx_q == LAST_IDX) begin
          state_d     = ST_PROG_H1;
          bus_start_c = 1'b1;
          bus_addr_c  = TMR_ADDR_CMPH;
          bus_data_c  = '1;
        end else begin
          scan_idx_d = scan_idx_q + CH_WIDTH'(1);
        end
      end
      ST_PROG_H1: begin
        if (bus_done_c) begin
          if (min_valid_q) begin
            state_d     = ST_PROG_L;
            bus_start_c = 1'b1;
            bus_addr_c  = TMR_ADDR_CMPL;
            bus_data_c  = min_val_q[31:0];
          end else begin
            state_d  = ST_SETTLE;
            settle_d = 1'b0;
            target_d = '1;
          end
        end
      end
      ST_PROG_L: begin
        if (bus_done_c) begin
          state_d     = ST_PROG_H2;
          bus_start_c = 1'b1;
          bus_addr_c  = TMR_ADDR_CMPH;
          bus_data_c  = min_val_q[63:32];
        end
      end
      ST_PROG_H2: begin
        if (bus_done_c) begin
          state_d  = ST_SETTLE;
          settle_d = 1'b0;
          target_d = min_val_q;
        end
      end
      // Two cycles for the timer to drop an interrupt raised by the old compare value.
      ST_SETTLE: begin
        if (settle_q) begin
          state_d = ST_IDLE;
        end else begin
          settle_d = 1'b1;
        end
      end
      ST_FIRE: begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
          fire_set_c[i] = armed_q[i] && (deadline_q[i] == target_q);
        end
        armed_d = armed_q & ~fire_set_c;
        dirty_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT_CR;
      end
    endcase
  end

  assign pending_d = (pending_q & ~pending_clear) | fire_set_c;

  assign arm_ready        = arm_ready_q;
  assign pending          = pending_q;
  assign irq              = irq_q;
  assign tmr_write_strobe = 4'hF;

endmodule

// File: doc/rvsteel_mtimer_scheduler.md
# rvsteel_mtimer_scheduler

Multiplexes `NUM_CHANNELS` independent 64-bit software deadlines onto the single compare register of the machine timer. Acts as the timer's bus master: enables it after reset, keeps `mtimecmp` programmed with the earliest armed deadline, and converts the timer interrupt into per-channel pending flags. Sits between the host-side channel interface and the timer's IO port.

## Interface

Parameters:
- `NUM_CHANNELS`, 4: number of deadline channels, 1..16.
- `CH_WIDTH`, `$clog2(NUM_CHANNELS)` (min 1): channel index width.

Ports:
- `clock`  in  1  sole clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `arm_valid`  in  1  host arm/cancel request.
- `arm_ready`  out  1  high only in IDLE; a transfer occurs when valid & ready.
- `arm_channel`  in  CH_WIDTH  target channel; out-of-range indices are ignored, but still accepted.
- `arm_enable`  in  1  1 = arm with `arm_deadline`, 0 = cancel.
- `arm_deadline`  in  64  absolute `mtime` value.
- `pending`  out  NUM_CHANNELS  per-channel expired flags.
- `pending_clear`  in  NUM_CHANNELS  write-1-to-clear.
- `irq`  out  1  `|pending`, registered.
- `tmr_rw_address`  out  5  timer register byte address.
- `tmr_write_data`  out  32.
- `tmr_write_strobe`  out  4  constant `4'hF`.
- `tmr_write_request`  out  1  one-cycle pulse.
- `tmr_write_response`  in  1.
- `tmr_irq`  in  1  timer interrupt.

## Operation

- Timer map: CR `0x00` (bit0 enable), MTIMECMPL `0x0C`, MTIMECMPH `0x10`. `mtime` is never written.
- State per channel:
  - `armed` bit.
  - 64-bit `deadline`.
  - `target` register: current programmed minimum, 64 bits.
  - `dirty` flag.
- FSM states:
  - INIT_CR: write CR=1.
  - IDLE: go to SCAN if `dirty`; else go to FIRE if `tmr_irq` and any channel is armed; else stay.
  - SCAN: one channel per cycle, index 0..N-1. Computes the minimum deadline over armed channels (ties go to the lowest index), with result `min_valid`/`min_val`. Clears `dirty` on entry.
  - PROG_H1: write CMPH=`32'hFFFF_FFFF` (glitch-free update).
  - PROG_L: write CMPL=`min_val[31:0]`. Skipped when `!min_valid`.
  - PROG_H2: write CMPH=`min_val[63:32]`. Skipped when `!min_valid`.
  - SETTLE: 2 cycles, masks stale `tmr_irq`, then IDLE.
  - FIRE: one cycle.
- `target` latches `min_val` at PROG_H2 completion, or all-ones when `!min_valid`.
- Each write state pulses the request for 1 cycle, then waits with the request low until `tmr_write_response`; then advances. There is no timeout.
- Arm/cancel (IDLE only): arm writes `armed`=`arm_enable` and `deadline` for the channel, then sets `dirty`.
- FIRE: every armed channel whose `deadline == target` gets `armed`←0 and `pending`←1. Then `dirty`←1, and the FSM returns to IDLE, which rescans.
- A deadline already in the past is handled normally: it becomes the target, the timer asserts its interrupt, and the channel fires after SETTLE.
- `pending` update rule: `pending <= (pending & ~pending_clear) | fire_set`. Set wins over a simultaneous clear.
- Arm of a channel whose `pending` is 1 does not clear `pending`.

## Timing

- Reset values: all outputs 0 except `tmr_write_strobe`=`4'hF`.
- Internal reset values: `armed`=0, `target`=all-ones, `dirty`=0, state INIT_CR.
- Reset deassertion to first `tmr_write_request`: 1 cycle.
- Each write takes 2 cycles against a single-cycle-response timer.
- Arm accept to mtimecmp fully updated: 1 (IDLE→SCAN) + N + 6 cycles. Then SETTLE 2, then IDLE.
- Cancel-all reprogramming: N+1 scan cycles + 2 cycles (PROG_H1 only) + 2 SETTLE cycles.
- `tmr_irq` is ignored outside IDLE. A deadline reached during SCAN/PROG is seen in IDLE.
- `pending`/`irq`: `irq` follows `pending` by 1 cycle. FIRE sets `pending` 1 cycle after IDLE samples `tmr_irq`.
- Reset mid-sequence: immediate return to INIT_CR; any half-written mtimecmp is harmless because all channels are disarmed.

## Structure

- Shared package:
  - timer register offset constants (CR, MTIMECMPL, MTIMECMPH);
  - CR enable bit position;
  - FSM state encoding.
- One natural sub-module: `rvsteel_mtimer_scheduler_bus`, the single-outstanding write master (issue pulse, wait response, `done` strobe).

## Test plan

- Reset, then the timer model: first write is addr `0x00` data `1`; `arm_ready` rises after it completes; `pending`=0, `irq`=0.
- Arm ch2 deadline 200, ch0 deadline 100 → write sequence `0x10`=FFFFFFFF, `0x0C`=100, `0x10`=0. At mtime≥100: `pending`=`4'b0001`; reprogram to 200; at mtime≥200: `pending`=`4'b0101`.
- Arm ch1 and ch3 both at 500 → both pending bits set in the same cycle; afterwards the final write is `0x10`=FFFFFFFF only.
- Arm ch0 at 1000, then cancel ch0 before expiry → no `pending` ever; last CMPH write is FFFFFFFF.
- Arm a deadline of 5 while mtime=50 → pending within SETTLE+2 cycles of programming.
- `pending_clear` asserted in the same cycle as FIRE on that channel → bit stays 1. Clearing on a later cycle → bit 0, and `irq` drops 1 cycle later.
- Extra boundary check: `reset_n` low during PROG_L → FSM in INIT_CR, `armed`=0, `tmr_write_request`=0.
